// File: rtl/pulse_serial_framer_pkg.sv
// Shared types and constants for the pulse-stepped serial frame receiver.
package pulse_serial_framer_pkg;

  localparam int LEN_W = 4;
  localparam logic [LEN_W-1:0] PATTERN_DEFAULT = 4'b1101;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2
  } framer_state_e;

endpackage

// File: rtl/pulse_serial_framer_one_pulser.sv
// Turns a button level into a single-cycle enable on each 0->1 transition.
// Optional PULSE_SYNC_EN adds a 2-flop synchronizer in front of the edge detector.
module one_pulser (
  input  logic clk,
  input  logic rst,
  input  logic in_pulse,
  output logic clk_en
);

  logic pulse_s;
  logic in_pulse_d_r;

`ifdef PULSE_SYNC_EN
  logic sync1_r;
  logic sync2_r;

  // Two-stage synchronizer; reset high so a held button never strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= in_pulse;
      sync2_r <= sync1_r;
    end
  end

  assign pulse_s = sync2_r;
`else
  assign pulse_s = in_pulse;
`endif

  // Rising-edge detector with registered strobe output.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_pulse_d_r <= 1'b1;
      clk_en       <= 1'b0;
    end else begin
      in_pulse_d_r <= pulse_s;
      clk_en       <= pulse_s & ~in_pulse_d_r;
    end
  end

endmodule

// File: rtl/pulse_serial_framer.sv
// Strobe-stepped serial receiver: hunt header, read 4-bit length, forward payload.
// Build option PULSE_SYNC_EN synchronizes in_pulse inside the one_pulser.
module pulse_serial_framer
  import pulse_serial_framer_pkg::*;
#(
  parameter logic [LEN_W-1:0] PATTERN = PATTERN_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_pulse,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic [LEN_W-1:0] cnt_out
);

  logic             clk_en;
  framer_state_e    state_r;
  logic [2:0]       hist_r;
  logic [1:0]       fill_r;
  logic [2:0]       len_r;
  logic [1:0]       len_idx_r;
  logic [LEN_W-1:0] hist_next_s;
  logic [LEN_W-1:0] len_next_s;

  one_pulser u_one_pulser (
    .clk      (clk),
    .rst      (rst),
    .in_pulse (in_pulse),
    .clk_en   (clk_en)
  );

  assign hist_next_s = {hist_r, ser_in};
  assign len_next_s  = {len_r, ser_in};

  // Frame FSM; everything advances only on strobe cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= HUNT;
      hist_r        <= 3'd0;
      fill_r        <= 2'd0;
      len_r         <= 3'd0;
      len_idx_r     <= 2'd0;
      ser_out       <= 1'b0;
      ser_out_valid <= 1'b0;
      cnt_out       <= 4'd0;
    end else if (clk_en) begin
      case (state_r)
        HUNT: begin
          hist_r        <= hist_next_s[2:0];
          fill_r        <= (fill_r == 2'd3) ? 2'd3 : fill_r + 2'd1;
          ser_out       <= 1'b0;
          ser_out_valid <= 1'b0;
          cnt_out       <= 4'd0;
          if ((fill_r == 2'd3) && (hist_next_s == PATTERN)) begin
            state_r   <= LEN;
            len_idx_r <= 2'd0;
          end else begin
            state_r <= HUNT;
          end
        end
        LEN: begin
          len_r     <= len_next_s[2:0];
          len_idx_r <= len_idx_r + 2'd1;
          if (len_idx_r == 2'd3) begin
            cnt_out <= len_next_s;
            // Zero-length frame returns straight to hunting with a clean history.
            if (len_next_s == 4'd0) begin
              state_r <= HUNT;
              hist_r  <= 3'd0;
              fill_r  <= 2'd0;
            end else begin
              state_r <= DATA;
            end
          end else begin
            state_r <= LEN;
          end
        end
        DATA: begin
          ser_out       <= ser_in;
          ser_out_valid <= 1'b1;
          cnt_out       <= (cnt_out == 4'd0) ? 4'd0 : cnt_out - 4'd1;
          if (cnt_out <= 4'd1) begin
            state_r <= HUNT;
            hist_r  <= 3'd0;
            fill_r  <= 2'd0;
          end else begin
            state_r <= DATA;
          end
        end
        default: begin
          state_r       <= HUNT;
          hist_r        <= 3'd0;
          fill_r        <= 2'd0;
          ser_out       <= 1'b0;
          ser_out_valid <= 1'b0;
          cnt_out       <= 4'd0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: tb/tb_pulse_serial_framer.sv
// Randomized self-checking bench for pulse_serial_framer against a queue-based frame model.
module tb_pulse_serial_framer;

`ifdef PULSE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic       in_pulse;
  logic       ser_in;
  logic       ser_out;
  logic       ser_out_valid;
  logic [3:0] cnt_out;

  int n_checks;
  int n_pass;

  // model state
  bit         hq[$];
  int         len_left;
  int         pay_left;
  int         lacc;
  int         exp_out;
  int         exp_valid;
  int         exp_cnt;

  pulse_serial_framer dut (
    .clk           (clk),
    .rst           (rst),
    .in_pulse      (in_pulse),
    .ser_in        (ser_in),
    .ser_out       (ser_out),
    .ser_out_valid (ser_out_valid),
    .cnt_out       (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    hq.delete();
    len_left  = 0;
    pay_left  = 0;
    lacc      = 0;
    exp_out   = 0;
    exp_valid = 0;
    exp_cnt   = 0;
  endtask

  // Frame rules: header of 4 consecutive strobed bits, 4 length bits, then payload.
  task automatic model_step(input bit b);
    int v;
    if (pay_left > 0) begin
      exp_out   = b;
      exp_valid = 1;
      pay_left--;
      exp_cnt   = pay_left;
      if (pay_left == 0) hq.delete();
    end else if (len_left > 0) begin
      lacc = lacc * 2 + b;
      len_left--;
      if (len_left == 0) begin
        pay_left = lacc;
        exp_cnt  = lacc;
        hq.delete();
      end
    end else begin
      exp_out   = 0;
      exp_valid = 0;
      exp_cnt   = 0;
      hq.push_back(b);
      if (hq.size() > 4) void'(hq.pop_front());
      if (hq.size() == 4) begin
        v = hq[0] * 8 + hq[1] * 4 + hq[2] * 2 + hq[3];
        if (v == 13) begin
          len_left = 4;
          lacc     = 0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_ser_out"}, int'(ser_out), exp_out);
    chk({tag, "_valid"}, int'(ser_out_valid), exp_valid);
    chk({tag, "_cnt"}, int'(cnt_out), exp_cnt);
  endtask

  // One button press carrying bit b; noise on ser_in outside the sampled cycle.
  task automatic strobe(input bit b, input int hi, input int lo);
    int npulse;
    int first;
    npulse = 0;
    first  = -1;
    ser_in   = b;
    in_pulse = 1'b1;
    for (int i = 1; i <= hi; i++) begin
      @(negedge clk);
      if (dut.clk_en) begin
        npulse++;
        if (first < 0) first = i;
      end
      if (i > LAT) ser_in = 1'($urandom_range(0, 1));
    end
    in_pulse = 1'b0;
    for (int i = 1; i <= lo; i++) begin
      @(negedge clk);
      if (dut.clk_en) npulse++;
      ser_in = 1'($urandom_range(0, 1));
    end
    chk("strobe_count", npulse, 1);
    chk("strobe_latency", first, LAT);
    model_step(b);
    check_outputs("strobe");
  endtask

  task automatic send(input bit bits[$], input int hi, input int lo);
    foreach (bits[k]) strobe(bits[k], hi, lo);
  endtask

  initial begin
    int npulse;
    bit seq[$];
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    rst      = 1'b1;
    in_pulse = 1'b1;
    ser_in   = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset");
    chk("reset_clk_en", int'(dut.clk_en), 0);
    rst = 1'b0;
    // Button already held at reset must not produce a strobe.
    npulse = 0;
    repeat (6) begin
      @(negedge clk);
      if (dut.clk_en) npulse++;
    end
    chk("held_at_reset", npulse, 0);
    in_pulse = 1'b0;
    repeat (3) @(negedge clk);

    // Directed frame: header at strobe 6, L=7, seven payload ones, then drop.
    seq = '{0, 0, 1, 1, 0, 1, 0, 1, 1, 1};
    send(seq, 10, 3);
    chk("len_loaded", int'(cnt_out), 7);
    seq = '{1, 1, 1, 1, 1, 1, 1, 1};
    send(seq, 10, 3);
    chk("dropped_valid", int'(ser_out_valid), 0);

    // Overlapping header then zero length.
    seq = '{1, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0};
    send(seq, 4, 2);

    // Maximum length with mixed payload.
    seq = '{1, 1, 0, 1, 1, 1, 1, 1};
    send(seq, 3, 2);
    chk("max_len", int'(cnt_out), 15);
    for (int i = 0; i < 16; i++) strobe(1'($urandom_range(0, 1)), 3, 2);

    // Reset in DATA with four bits left.
    seq = '{1, 1, 0, 1, 0, 1, 1, 0, 1, 0};
    send(seq, 3, 2);
    chk("pre_reset_cnt", int'(cnt_out), 4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_outputs("mid_reset");
    repeat (2) @(negedge clk);
    seq = '{1, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    send(seq, 3, 2);

    // Random traffic.
    for (int i = 0; i < 250; i++)
      strobe(1'($urandom_range(0, 3) != 0), $urandom_range(3, 6), $urandom_range(2, 4));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
